exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset; no other clock or reset inputs.
REQ-002 Parameter: VEC_BASE, default 64'h0000_0000_0000_00D8, exception handler entry address.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 EStatus  input  4  exception code from main decoder; 4'b0000 = none.
REQ-006 ERet  input  1  decoded ERET instruction in current cycle.
REQ-007 PC  input  64  address of instruction executing in current cycle.
REQ-008 ExtIRQ  input  1  external interrupt request, level, asynchronous to clk.
REQ-009 Exc  output  1  take exception this cycle; PC mux selects ExcVector.
REQ-010 ExcVector  output  64  constant VEC_BASE.
REQ-011 ERetPC  output  64  return target; equals ELR.
REQ-012 ELR  output  64  saved exception link register.
REQ-013 ESR  output  64  syndrome: {60'b0, cause code}.
REQ-014 Flush  output  1  kill RegWrite/MemWrite/MemRead of current instruction.
REQ-015 InHandler  output  1  high while state = HANDLER.
REQ-016 Halt  output  1  double-fault lock-up indicator.

Function
REQ-017 FSM states NORMAL, HANDLER, LOCKUP, encoded 2 bits; InHandler = (state==HANDLER), Halt = (state==LOCKUP).
REQ-018 Cause codes (package): 4'b0001 invalid opcode, 4'b0010 external IRQ, 4'b0011 ERET outside handler; any other nonzero EStatus is passed through to ESR unchanged.
REQ-019 NORMAL, EStatus!=0: Exc=1 and Flush=1 combinationally same cycle; at next edge ELR<=PC, ESR<={60'b0,EStatus}, state<=HANDLER.
REQ-020 NORMAL, ERet=1, EStatus==0: treated as exception with cause 4'b0011, identical timing to REQ-019.
REQ-021 NORMAL, IRQ pending, no sync cause: Exc=1, Flush=1; next edge ELR<=PC (instruction re-executed on return), ESR<=cause 4'b0010, pending cleared, state<=HANDLER.
REQ-022 Priority: synchronous cause (EStatus, bad ERET) > IRQ; a losing IRQ stays pending.
REQ-023 HANDLER, ERet=1, EStatus==0: Exc=0, Flush=0, ERetPC=ELR valid same cycle; next edge state<=NORMAL; ELR/ESR hold.
REQ-024 HANDLER, EStatus!=0: Flush=1, Exc=0; next edge state<=LOCKUP; ELR/ESR hold (first fault preserved).
REQ-025 HANDLER: IRQ not taken; pending flag set/held, taken first cycle after return to NORMAL.
REQ-026 LOCKUP: Flush=1 every cycle, Exc=0; exits only by reset.
REQ-027 ELR and ESR change only on exception entry edges; otherwise hold.
REQ-028 Exc, Flush combinational from state, EStatus, ERet, pending only; no combinational path from PC to Exc.

Reset
REQ-029 On reset assertion, immediately: state=NORMAL, ELR=0, ESR=0, IRQ pending=0, synchronizer flops=0; Exc/Flush/InHandler/Halt=0.
REQ-030 Reset mid-HANDLER or mid-LOCKUP SHALL abandon state with no return performed.

Configuration
REQ-031 Macro EXC_IRQ_EN: defined -> ExtIRQ passes 2-flop synchronizer, pending set on synchronized level high while no entry for it occurs, REQ-021/022/025 apply.
REQ-032 EXC_IRQ_EN undefined -> ExtIRQ port kept but ignored, no synchronizer/pending flops, cause 4'b0010 never produced.

Structure
REQ-033 Package exc_pkg: state enum typedef, cause code localparams, default VEC_BASE localparam.
REQ-034 One sub-module irq_sync (2-flop synchronizer, clk/reset), instantiated only under EXC_IRQ_EN.

Verification
REQ-035 NORMAL, PC=0x40, EStatus=0001 -> Exc=1, Flush=1 same cycle; next cycle ELR=0x40, ESR=1, InHandler=1.
REQ-036 HANDLER, ELR=0x40, ERet=1 -> ERetPC=0x40, Exc=0; next cycle InHandler=0, ELR still 0x40.
REQ-037 NORMAL, ERet=1, PC=0x10 -> Exc=1; next cycle ESR=3, ELR=0x10.
REQ-038 HANDLER, EStatus=0001 -> Flush=1; next cycle Halt=1, ESR/ELR unchanged; reset -> Halt=0, ELR=0.
REQ-039 EXC_IRQ_EN: ExtIRQ pulse 1 cycle while HANDLER -> no Exc; after ERet, Exc=1 in NORMAL, ESR=2, ELR=PC of that cycle.
REQ-040 EXC_IRQ_EN: IRQ pending and EStatus=0001 same cycle, PC=0x80 -> ESR=1 next cycle; IRQ taken after return, ESR=2.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller.
package exc_pkg;
  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    HANDLER = 2'd1,
    LOCKUP  = 2'd2
  } exc_state_t;

  localparam logic [3:0] CAUSE_NONE     = 4'b0000;
  localparam logic [3:0] CAUSE_INV_OP   = 4'b0001;
  localparam logic [3:0] CAUSE_IRQ      = 4'b0010;
  localparam logic [3:0] CAUSE_BAD_ERET = 4'b0011;

  localparam logic [63:0] VEC_BASE_DEF = 64'h0000_0000_0000_00D8;
endpackage

// File: rtl/exc_ctrl_if.sv
// Pipeline <-> exception controller signal bundle.
interface exc_ctrl_if;
  logic [3:0]  EStatus;
  logic        ERet;
  logic [63:0] PC;
  logic        ExtIRQ;
  logic        Exc;
  logic [63:0] ExcVector;
  logic [63:0] ERetPC;
  logic [63:0] ELR;
  logic [63:0] ESR;
  logic        Flush;
  logic        InHandler;
  logic        Halt;

  modport master (
    output EStatus, ERet, PC, ExtIRQ,
    input  Exc, ExcVector, ERetPC, ELR, ESR, Flush, InHandler, Halt
  );
  modport slave (
    input  EStatus, ERet, PC, ExtIRQ,
    output Exc, ExcVector, ERetPC, ELR, ESR, Flush, InHandler, Halt
  );
endinterface

// File: rtl/exc_ctrl_irq_sync.sv
// Two-flop synchronizer for the asynchronous external interrupt level.
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic ff1, ff2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff1 <= 1'b0;
      ff2 <= 1'b0;
    end else begin
      ff1 <= d;
      ff2 <= ff1;
    end
  end

  assign q = ff2;
endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: NORMAL/HANDLER/LOCKUP FSM with ELR/ESR capture.
// Define EXC_IRQ_EN to enable the synchronized external interrupt path.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [63:0] VEC_BASE = VEC_BASE_DEF
) (
  input logic       clk,
  input logic       reset,
  exc_ctrl_if.slave bus
);
  exc_state_t  state, state_d;
  logic [63:0] elr;
  logic [3:0]  esr, cause;
  logic        exc, flush, irq_ent, pend;

`ifdef EXC_IRQ_EN
  logic irq_s;

  irq_sync u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.ExtIRQ),
    .q     (irq_s)
  );

  // Pending is cleared only on the edge that actually enters for the IRQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend <= 1'b0;
    else       pend <= ~irq_ent & (pend | irq_s);
  end
`else
  logic unused_irq;
  assign unused_irq = bus.ExtIRQ | irq_ent;
  assign pend       = 1'b0;
`endif

  always_comb begin
    state_d = state;
    exc     = 1'b0;
    flush   = 1'b0;
    cause   = CAUSE_NONE;
    irq_ent = 1'b0;
    case (state)
      NORMAL: begin
        if (bus.EStatus != CAUSE_NONE) begin
          exc = 1'b1; flush = 1'b1; cause = bus.EStatus; state_d = HANDLER;
        end else if (bus.ERet) begin
          exc = 1'b1; flush = 1'b1; cause = CAUSE_BAD_ERET; state_d = HANDLER;
        end else if (pend) begin
          exc = 1'b1; flush = 1'b1; cause = CAUSE_IRQ; state_d = HANDLER;
          irq_ent = 1'b1;
        end
      end
      HANDLER: begin
        // A fault inside the handler wins over a simultaneous ERET.
        if (bus.EStatus != CAUSE_NONE) begin
          flush = 1'b1; state_d = LOCKUP;
        end else if (bus.ERet) begin
          state_d = NORMAL;
        end
      end
      LOCKUP:  flush = 1'b1;
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= NORMAL;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elr <= '0;
      esr <= CAUSE_NONE;
    end else if (exc) begin
      elr <= bus.PC;
      esr <= cause;
    end
  end

  assign bus.Exc       = exc & ~reset;
  assign bus.Flush     = flush & ~reset;
  assign bus.ExcVector = VEC_BASE;
  assign bus.ELR       = elr;
  assign bus.ERetPC    = elr;
  assign bus.ESR       = {60'b0, esr};
  assign bus.InHandler = (state == HANDLER);
  assign bus.Halt      = (state == LOCKUP);
endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: directed cycles push expectations, a negedge monitor checks.
module tb_exc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exc_ctrl_if bus ();

  exc_ctrl dut (.clk(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        exc, flush, inh, halt;
    logic [63:0] elr;
    logic [3:0]  esr;
    string       nm;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_fail = 0;
  localparam logic [63:0] VEC = 64'h0000_0000_0000_00D8;

  task automatic step(input bit r, input logic [3:0] es, input bit er, input logic [63:0] pc,
                      input bit irq, input bit e_exc, input bit e_fl, input bit e_inh,
                      input bit e_halt, input logic [63:0] e_elr, input logic [3:0] e_esr,
                      input string nm);
    exp_t e;
    @(posedge clk); #1;
    rst = r; bus.EStatus = es; bus.ERet = er; bus.PC = pc; bus.ExtIRQ = irq;
    e.exc = e_exc; e.flush = e_fl; e.inh = e_inh; e.halt = e_halt;
    e.elr = e_elr; e.esr = e_esr; e.nm = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (bus.Exc !== e.exc || bus.Flush !== e.flush || bus.InHandler !== e.inh ||
          bus.Halt !== e.halt || bus.ELR !== e.elr || bus.ESR !== {60'b0, e.esr} ||
          bus.ERetPC !== e.elr || bus.ExcVector !== VEC) begin
        n_fail++;
        $display("FAIL %s: got exc=%b flush=%b inh=%b halt=%b elr=%h esr=%h eretpc=%h vec=%h; want exc=%b flush=%b inh=%b halt=%b elr=%h esr=%h vec=%h",
                 e.nm, bus.Exc, bus.Flush, bus.InHandler, bus.Halt, bus.ELR, bus.ESR,
                 bus.ERetPC, bus.ExcVector, e.exc, e.flush, e.inh, e.halt, e.elr,
                 {60'b0, e.esr}, VEC);
      end
    end
  end

  initial begin
    bus.EStatus = 4'd1; bus.ERet = 1'b0; bus.PC = 64'h40; bus.ExtIRQ = 1'b0;
    //    rst es  er pc    irq exc fl inh hlt elr    esr
    step(1, 1, 0, 64'h40, 0, 0, 0, 0, 0, 64'h0,  4'h0, "reset");
    step(0, 0, 0, 64'h00, 0, 0, 0, 0, 0, 64'h0,  4'h0, "idle");
    step(0, 1, 0, 64'h40, 0, 1, 1, 0, 0, 64'h0,  4'h0, "invop_entry");
    step(0, 0, 0, 64'hD8, 0, 0, 0, 1, 0, 64'h40, 4'h1, "in_handler");
    step(0, 0, 1, 64'hDC, 0, 0, 0, 1, 0, 64'h40, 4'h1, "eret_in_handler");
    step(0, 0, 0, 64'h40, 0, 0, 0, 0, 0, 64'h40, 4'h1, "after_eret");
    step(0, 0, 1, 64'h10, 0, 1, 1, 0, 0, 64'h40, 4'h1, "bad_eret_entry");
    step(0, 0, 0, 64'hD8, 0, 0, 0, 1, 0, 64'h10, 4'h3, "bad_eret_cause");
    step(0, 0, 1, 64'hDC, 0, 0, 0, 1, 0, 64'h10, 4'h3, "eret2");
    step(0, 4'hA, 0, 64'h20, 0, 1, 1, 0, 0, 64'h10, 4'h3, "passthru_entry");
    step(0, 0, 0, 64'hD8, 0, 0, 0, 1, 0, 64'h20, 4'hA, "passthru_cause");
    step(0, 1, 1, 64'h24, 0, 0, 1, 1, 0, 64'h20, 4'hA, "double_fault");
    step(0, 0, 0, 64'h28, 0, 0, 1, 0, 1, 64'h20, 4'hA, "lockup");
    step(0, 0, 1, 64'h2C, 0, 0, 1, 0, 1, 64'h20, 4'hA, "lockup_eret");
    step(0, 5, 0, 64'h30, 0, 0, 1, 0, 1, 64'h20, 4'hA, "lockup_fault");
    step(1, 1, 0, 64'h30, 0, 0, 0, 0, 0, 64'h0,  4'h0, "reset_lockup");
    step(0, 0, 0, 64'h00, 0, 0, 0, 0, 0, 64'h0,  4'h0, "post_reset");
    step(0, 2, 0, 64'h30, 0, 1, 1, 0, 0, 64'h0,  4'h0, "code2_entry");
    step(0, 0, 0, 64'hD8, 0, 0, 0, 1, 0, 64'h30, 4'h2, "code2_cause");
    step(1, 0, 0, 64'hD8, 0, 0, 0, 0, 0, 64'h0,  4'h0, "reset_handler");
    step(0, 0, 1, 64'h50, 0, 1, 1, 0, 0, 64'h0,  4'h0, "eret_after_reset");
    step(0, 0, 0, 64'hD8, 0, 0, 0, 1, 0, 64'h50, 4'h3, "eret_after_reset_cause");
    step(0, 0, 1, 64'hDC, 0, 0, 0, 1, 0, 64'h50, 4'h3, "eret3");
    step(0, 0, 0, 64'h54, 0, 0, 0, 0, 0, 64'h50, 4'h3, "normal_idle");
`ifdef EXC_IRQ_EN
    // IRQ pulse while in handler is deferred until after return
    step(0, 1, 0, 64'h60, 0, 1, 1, 0, 0, 64'h50, 4'h3, "irqh_entry");
    step(0, 0, 0, 64'hD8, 1, 0, 0, 1, 0, 64'h60, 4'h1, "irqh_pulse");
    step(0, 0, 0, 64'hDC, 0, 0, 0, 1, 0, 64'h60, 4'h1, "irqh_wait1");
    step(0, 0, 0, 64'hE0, 0, 0, 0, 1, 0, 64'h60, 4'h1, "irqh_wait2");
    step(0, 0, 0, 64'hE4, 0, 0, 0, 1, 0, 64'h60, 4'h1, "irqh_wait3");
    step(0, 0, 1, 64'hE8, 0, 0, 0, 1, 0, 64'h60, 4'h1, "irqh_eret");
    step(0, 0, 0, 64'h70, 0, 1, 1, 0, 0, 64'h60, 4'h1, "irq_taken");
    step(0, 0, 0, 64'hD8, 0, 0, 0, 1, 0, 64'h70, 4'h2, "irq_cause");
    step(0, 0, 1, 64'hDC, 0, 0, 0, 1, 0, 64'h70, 4'h2, "irq_eret");
    step(0, 0, 0, 64'h74, 0, 0, 0, 0, 0, 64'h70, 4'h2, "irq_cleared");
    // sync fault beats a pending IRQ; IRQ follows after return
    step(0, 0, 0, 64'h78, 1, 0, 0, 0, 0, 64'h70, 4'h2, "prio_pulse");
    step(0, 0, 0, 64'h7C, 0, 0, 0, 0, 0, 64'h70, 4'h2, "prio_sync1");
    step(0, 0, 0, 64'h7E, 0, 0, 0, 0, 0, 64'h70, 4'h2, "prio_sync2");
    step(0, 1, 0, 64'h80, 0, 1, 1, 0, 0, 64'h70, 4'h2, "prio_fault");
    step(0, 0, 0, 64'hD8, 0, 0, 0, 1, 0, 64'h80, 4'h1, "prio_cause");
    step(0, 0, 1, 64'hDC, 0, 0, 0, 1, 0, 64'h80, 4'h1, "prio_eret");
    step(0, 0, 0, 64'h90, 0, 1, 1, 0, 0, 64'h80, 4'h1, "prio_irq_taken");
    step(0, 0, 0, 64'hD8, 0, 0, 0, 1, 0, 64'h90, 4'h2, "prio_irq_cause");
    step(0, 0, 1, 64'hDC, 0, 0, 0, 1, 0, 64'h90, 4'h2, "prio_irq_eret");
    step(0, 0, 0, 64'h94, 0, 0, 0, 0, 0, 64'h90, 4'h2, "prio_done");
`else
    // ExtIRQ is ignored entirely in this build
    for (int i = 0; i < 6; i++)
      step(0, 0, 0, 64'h58, 1, 0, 0, 0, 0, 64'h50, 4'h3, "irq_ignored");
    step(0, 0, 0, 64'h5C, 0, 0, 0, 0, 0, 64'h50, 4'h3, "irq_ignored_end");
`endif
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
